// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin arbiter sharing one spi_core among NREQ requesters (optional watchdog via SPI_ARB_TIMEOUT_EN)
module spi_xfer_arbiter #(
    parameter int NREQ           = 4,
    parameter int DW             = 32,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic               go_transfer,
    output logic [DW-1:0]      data_write_to_spi,
    input  logic [DW-1:0]      data_read_from_spi,
    input  logic               data_pack_ready,
    output logic               busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;

    logic [1:0]    state;
    logic [IW-1:0] last;
    logic [IW-1:0] win;
    logic [IW-1:0] sel;
    logic [IW-1:0] cand;
    logic          found;
    logic [GW-1:0] gcnt;
    logic          dpr_q;
    logic          rise;
    logic          tmo;
    logic [DW-1:0] words [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words[i] = req_data[i*DW +: DW];
    end

    assign busy = state != S_IDLE;
    assign rise = data_pack_ready & ~dpr_q;

    // Pick the first pending requester searching upward from last+1; descending loop leaves the nearest one
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Completion pulse tracker: follows the input in every state so a level held on WAIT entry is not an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dpr_q <= 1'b0;
        else          dpr_q <= data_pack_ready;
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    assign tmo = (state == S_WAIT) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts clocks spent in WAIT and flags a timeout unless a real completion lands on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt    <= '0;
            rsp_err <= 1'b0;
        end else begin
            tcnt <= (state == S_WAIT) ? tcnt + 1'b1 : '0;
            if (state == S_WAIT && (rise || tmo)) rsp_err <= ~rise;
        end
    end
`else
    assign tmo     = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Main sequencer: grant in IDLE, wait for the core's completion edge, then hold off for the idle gap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            grant             <= '0;
            done              <= '0;
            go_transfer       <= 1'b0;
            rsp_data          <= '0;
            data_write_to_spi <= '0;
            last              <= IW'(NREQ - 1);
            win               <= '0;
            gcnt              <= '0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: if (found) begin
                    grant             <= NREQ'(1) << sel;
                    win               <= sel;
                    data_write_to_spi <= words[sel];
                    go_transfer       <= 1'b1;
                    state             <= S_WAIT;
                end
                S_WAIT: if (rise || tmo) begin
                    done        <= grant;
                    rsp_data    <= rise ? data_read_from_spi : '0;
                    grant       <= '0;
                    go_transfer <= 1'b0;
                    last        <= win;
                    gcnt        <= GW'(GAP_CYCLES);
                    state       <= GAP_CYCLES == 0 ? S_IDLE : S_GAP;
                end
                S_GAP: if (gcnt <= GW'(1)) state <= S_IDLE;
                       else gcnt <= gcnt - 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: randomized self-checking bench for spi_xfer_arbiter against a round-robin reference model
module tb_spi_xfer_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int GAP  = 4;
    localparam int TO   = 64;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               go_transfer;
    logic [DW-1:0]      data_write_to_spi;
    logic [DW-1:0]      data_read_from_spi = '0;
    logic               data_pack_ready = 1'b0;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_m = NREQ - 1;
    int grant_cyc = 0;
    int done_cyc = 0;
    logic [DW-1:0]   wd [NREQ];
    logic [NREQ-1:0] prev_done = '0;

    spi_xfer_arbiter #(.NREQ(NREQ), .DW(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .go_transfer(go_transfer), .data_write_to_spi(data_write_to_spi),
        .data_read_from_spi(data_read_from_spi), .data_pack_ready(data_pack_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if ($countones(grant) > 1 || $countones(done) > 1 || (done != 0 && prev_done != 0) ||
                (go_transfer && (!busy || grant == 0))) begin
                errors++;
                $display("FAIL invariant grant=%b done=%b prev_done=%b go=%b busy=%b", grant, done, prev_done, go_transfer, busy);
            end
            prev_done = done;
        end else prev_done = '0;
    end

    function automatic int pick(input logic [NREQ-1:0] r, input int l);
        for (int k = 1; k <= NREQ; k++) if (r[(l + k) % NREQ]) return (l + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_data;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = wd[i];
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        req = '0;
        data_pack_ready = 1'b0;
        repeat (2) tick;
        reset_n = 1'b1;
        tick;
        last_m = NREQ - 1;
    endtask

    task automatic wait_grant(input int exp);
        int n;
        n = 0;
        while (grant == 0 && n < 60) begin
            tick;
            n++;
        end
        grant_cyc = cyc;
        checks++;
        if (grant !== onehot(exp)) begin
            errors++;
            $display("FAIL grant got %b exp %b", grant, onehot(exp));
        end
        checks++;
        if (exp >= 0 && data_write_to_spi !== wd[exp]) begin
            errors++;
            $display("FAIL wdata got %h exp %h", data_write_to_spi, wd[exp]);
        end
        checks++;
        if (go_transfer !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL go_busy got go=%b busy=%b exp 1 1", go_transfer, busy);
        end
    endtask

    task automatic finish_frame(input int exp, input int lat, input logic [DW-1:0] rd);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < lat; i++) begin
            tick;
            if (done !== '0 || go_transfer !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL in_flight early completion or go drop during %0d clocks", lat);
        end
        data_read_from_spi = rd;
        data_pack_ready = 1'b1;
        tick;
        done_cyc = cyc;
        checks++;
        if (done !== onehot(exp) || rsp_data !== rd || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL done got %b/%h/%b exp %b/%h/0", done, rsp_data, rsp_err, onehot(exp), rd);
        end
        checks++;
        if (go_transfer !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL release got go=%b grant=%b exp 0 0", go_transfer, grant);
        end
        last_m = exp;
        data_pack_ready = 1'b0;
        data_read_from_spi = $urandom;
        tick;
        checks++;
        if (done !== '0 || rsp_data !== rd) begin
            errors++;
            $display("FAIL done_width got done=%b rsp=%h exp 0 %h", done, rsp_data, rd);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        checks++;
        if ({grant, done, go_transfer, busy, rsp_err, rsp_data, data_write_to_spi} !== '0) begin
            errors++;
            $display("FAIL reset got grant=%b done=%b go=%b busy=%b err=%b rsp=%h wd=%h exp all 0",
                     grant, done, go_transfer, busy, rsp_err, rsp_data, data_write_to_spi);
        end
        reset_n = 1'b1;
        repeat (3) tick;
        checks++;
        if (busy !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL idle_no_req got busy=%b grant=%b exp 0 0", busy, grant);
        end
    endtask

    task automatic test_single;
        int c0;
        apply_reset;
        for (int i = 0; i < NREQ; i++) wd[i] = $urandom;
        wd[2] = 32'hA5A5_0001;
        load_data;
        req = 4'b0100;
        c0 = cyc;
        tick;
        wait_grant(2);
        checks++;
        if (grant_cyc - c0 != 1) begin
            errors++;
            $display("FAIL grant_latency got %0d exp 1", grant_cyc - c0);
        end
        req = '0;
        finish_frame(2, 39, 32'h1234_5678);
    endtask

    task automatic test_round_robin;
        int exp;
        apply_reset;
        for (int i = 0; i < NREQ; i++) wd[i] = $urandom;
        load_data;
        req = '1;
        for (int i = 0; i < 5; i++) begin
            exp = pick(req, last_m);
            wait_grant(exp);
            if (i > 0) begin
                checks++;
                if (grant_cyc - done_cyc != GAP + 1) begin
                    errors++;
                    $display("FAIL rr_gap got %0d exp %0d", grant_cyc - done_cyc, GAP + 1);
                end
            end
            finish_frame(exp, $urandom_range(2, 20), $urandom);
        end
        req = '0;
    endtask

    task automatic test_req_drop;
        for (int i = 0; i < NREQ; i++) wd[i] = $urandom;
        load_data;
        req = 4'b0010;
        wait_grant(pick(req, last_m));
        repeat (3) tick;
        req = '0;
        finish_frame(1, 5, $urandom);
        repeat (8) tick;
        checks++;
        if (busy !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL drop_idle got busy=%b grant=%b exp 0 0", busy, grant);
        end
    endtask

    task automatic test_stale_level;
        bit ok;
        data_pack_ready = 1'b1;
        data_read_from_spi = $urandom;
        tick;
        wd[3] = $urandom;
        load_data;
        req = 4'b1000;
        wait_grant(pick(req, last_m));
        req = '0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done !== '0 || go_transfer !== 1'b1) ok = 1'b0;
        end
        data_pack_ready = 1'b0;
        tick;
        if (done !== '0 || go_transfer !== 1'b1) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stale_level completion taken from level held on entry");
        end
        finish_frame(3, 0, $urandom);
    endtask

    task automatic test_random;
        int exp;
        logic [NREQ-1:0] r;
        for (int it = 0; it < 14; it++) begin
            do r = NREQ'($urandom); while (r == '0);
            for (int i = 0; i < NREQ; i++) wd[i] = $urandom;
            load_data;
            req = r;
            exp = pick(req, last_m);
            wait_grant(exp);
            if (it > 0) begin
                checks++;
                if (grant_cyc - done_cyc != GAP + 1) begin
                    errors++;
                    $display("FAIL rand_gap got %0d exp %0d", grant_cyc - done_cyc, GAP + 1);
                end
            end
            if ($urandom_range(0, 1) == 1) req[exp] = 1'b0;
            finish_frame(exp, $urandom_range(1, 20), $urandom);
        end
        req = '0;
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int exp;
        int n;
        for (int i = 0; i < NREQ; i++) wd[i] = $urandom;
        load_data;
        repeat (GAP + 2) tick;
        req = 4'b0110;
        exp = pick(req, last_m);
        wait_grant(exp);
        n = 0;
        while (done == '0 && n < TO + 10) begin
            tick;
            n++;
        end
        done_cyc = cyc;
        checks++;
        if (done_cyc - grant_cyc != TO || done !== onehot(exp)) begin
            errors++;
            $display("FAIL timeout_time got %0d done=%b exp %0d %b", done_cyc - grant_cyc, done, TO, onehot(exp));
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_data !== '0 || go_transfer !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL timeout_rsp got err=%b rsp=%h go=%b grant=%b exp 1 0 0 0", rsp_err, rsp_data, go_transfer, grant);
        end
        last_m = exp;
        req[exp] = 1'b0;
        tick;
        exp = pick(req, last_m);
        wait_grant(exp);
        checks++;
        if (grant_cyc - done_cyc != GAP + 1) begin
            errors++;
            $display("FAIL timeout_gap got %0d exp %0d", grant_cyc - done_cyc, GAP + 1);
        end
        req = '0;
        finish_frame(exp, 3, $urandom);
    endtask
`endif

    task automatic test_midframe_reset;
        for (int i = 0; i < NREQ; i++) wd[i] = $urandom;
        load_data;
        req = 4'b0100;
        wait_grant(pick(req, last_m));
        repeat (3) tick;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({grant, done, go_transfer, busy, rsp_err, rsp_data, data_write_to_spi} !== '0) begin
            errors++;
            $display("FAIL async_reset got grant=%b done=%b go=%b busy=%b err=%b rsp=%h wd=%h exp all 0",
                     grant, done, go_transfer, busy, rsp_err, rsp_data, data_write_to_spi);
        end
        tick;
        req = '1;
        last_m = NREQ - 1;
        reset_n = 1'b1;
        tick;
        wait_grant(0);
        finish_frame(0, 4, $urandom);
        req = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_req_drop;
        test_stale_level;
        test_random;
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout;
`endif
        test_midframe_reset;
        repeat (2) tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
